// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a single-port data memory.
// Optional `LSU_TRACE_EN adds simulation-only store/load trace prints.
module lsu_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] WAIT_LAST = WAIT_CYCLES[3:0];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        req_illegal;
  logic        last_access;
  logic [3:0]  lane_mask;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  assign accept      = req_valid && (state_q == IDLE);
  assign last_access = (state_q == ACCESS) && (cnt_q == WAIT_LAST);

  always_comb begin
    req_illegal = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_illegal = 1'b1;
    end else if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) begin
      req_illegal = 1'b1;
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0])          req_illegal = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) req_illegal = 1'b1;
  end

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    lane_mask = 4'b0001 << lane_mask_sh(lane_q);
      2'd1:    lane_mask = 4'b0011 << lane_mask_sh(lane_q);
      default: lane_mask = 4'b1111;
    endcase
  end

  function automatic logic [1:0] lane_mask_sh(input logic [1:0] k);
    return k;
  endfunction

  // Loads pick their byte/half out of the word by shifting the addressed lane down to bit 0.
  assign rd_shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_data = '0;
    if (!we_q) begin
      case (funct3_q)
        3'd0:    load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
        3'd1:    load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
        3'd4:    load_data = {24'h0, rd_shifted[7:0]};
        3'd5:    load_data = {16'h0, rd_shifted[15:0]};
        default: load_data = mem_rdata;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_illegal ? RESP : ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (last_access) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      funct3_q     <= '0;
      lane_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      lane_q   <= req_addr[1:0];
      if (req_illegal) begin
        resp_err_q   <= 1'b1;
        resp_rdata_q <= '0;
      end else begin
        resp_err_q <= 1'b0;
        addr_q     <= {req_addr[31:2], 2'b00};
        wdata_q    <= req_wdata << {req_addr[1:0], 3'b000};
      end
    end else if (last_access) begin
      resp_rdata_q <= load_data;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_valid  = (state_q == ACCESS);
  assign mem_wen    = last_access && we_q;
  assign mem_raddr  = addr_q;
  assign mem_waddr  = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = {4'h0, (state_q == ACCESS) ? lane_mask : 4'h0};

`ifdef LSU_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_wen)
        $display("st addr=%h data=%h mask=%h", mem_waddr, mem_wdata, mem_wmask);
      else if (last_access)
        $display("ld addr=%h data=%h", mem_raddr, load_data);
    end
  end
`endif

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the pipeline MEM stage and the data-memory port: valid/wen, word address, wdata, 8-bit wmask, combinational rdata.
- Accepts one load/store at a time over a valid/ready handshake.
- Aligns store data, generates byte masks, and drives the memory port for a programmable number of wait cycles.
- Extracts and sign/zero-extends load data, and returns a registered response with an error flag for misaligned or illegal accesses.

Parameters:
- WAIT_CYCLES, 0: extra cycles mem_valid is held before rdata is captured (0..15); emulates slower SRAM.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  pipeline request valid
- req_ready  output  1  block can accept a request
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32 funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-justified
- resp_valid  output  1  response valid
- resp_ready  input  1  pipeline accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal funct3
- mem_valid  output  1  memory access strobe
- mem_wen  output  1  memory write enable
- mem_raddr  output  32  word-aligned read address
- mem_waddr  output  32  word-aligned write address
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  8  byte mask; bits [7:4] always 0
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset:
  - The FSM returns to IDLE asynchronously.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_wen=0, mem_raddr/waddr/wdata=0, mem_wmask=0, wait counter=0.
  - req_ready=1 after reset (req_ready = state==IDLE).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On req_valid&&req_ready, latch we, funct3, addr, wdata.
  - If the request is illegal, go to RESP with resp_err=1, resp_rdata=0, and make no memory access.
  - Otherwise go to ACCESS with counter=0.
- Illegal requests:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Load funct3 in {3,6,7}.
  - Store funct3 not in {0,1,2}.
- ACCESS:
  - mem_valid=1; mem_raddr=mem_waddr={addr[31:2],2'b00}.
  - Counter increments each cycle.
  - mem_wen=req_we only on the final ACCESS cycle (counter==WAIT_CYCLES), so exactly one write pulse occurs.
  - Final cycle: register the extracted load data into resp_rdata, then go to RESP.
- Byte lane k=addr[1:0]:
  - Byte: mem_wmask=1<<k.
  - Half: mem_wmask=3<<k.
  - Word: mem_wmask=4'hF.
  - mem_wdata=req_wdata<<(8*k), with bits outside the mask don't-care but driven as the shifted value.
- Load extract:
  - Byte = mem_rdata[8k+:8]; half = mem_rdata[8k+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Memory outputs in IDLE/RESP: mem_valid=0, mem_wen=0, mem_wmask=0; addresses/data hold their last values.
- RESP:
  - resp_valid=1; resp_rdata/resp_err are stable until resp_valid&&resp_ready, then go to IDLE.
  - req_ready=0 in ACCESS and RESP, so there is no back-to-back acceptance. Throughput is 1 request per WAIT_CYCLES+3 cycles when resp_ready=1.
- Latency: a request accepted at edge N gives ACCESS in cycles N+1..N+1+WAIT_CYCLES, and resp_valid is first high in cycle N+2+WAIT_CYCLES.
- Reset asserted mid-ACCESS: mem_valid/mem_wen drop immediately (asynchronous); the in-flight request is discarded with no response.
- Address wrap: addresses are not incremented; 0xFFFF_FFFC is legal.

Optional Feature:
- LSU_TRACE_EN:
  - Defined: a simulation-only $display on each write pulse ("st addr=%h data=%h mask=%h") and on each load capture ("ld addr=%h data=%h"). There is no functional change.
  - Undefined: no display code is compiled; RTL stays synthesizable and cycle-identical.

Test Plan:
- Reset, then req LW addr=0x8000_0004, memory word 0x1234_5678, WAIT_CYCLES=0 -> mem_valid 1 for one cycle with raddr 0x8000_0004; resp_valid 2 cycles after accept; rdata=0x1234_5678, err=0.
- LB addr=0x8000_0003 with mem_rdata=0x80AA_BBCC -> rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr=0x8000_0102 wdata=0x0000_BEEF -> mem_wmask=0x0C, mem_wdata=0xBEEF_0000, mem_wen high exactly one cycle, waddr=0x8000_0100.
- LW addr=0x8000_0002 -> no mem_valid pulse, resp_err=1, rdata=0; funct3=3 load -> resp_err=1.
- WAIT_CYCLES=3, SW with resp_ready held 0 for 4 cycles -> mem_valid high 4 cycles with wen only on the last; resp_valid stable until resp_ready=1; req_ready=0 throughout.
- rst_n low during the 2nd ACCESS cycle -> mem_valid=0 same cycle, no resp_valid; after release req_ready=1 and the next LW completes normally.
